// File: rtl/seq_nibble_comp_if.sv
// -----------------------------------------------------------------------------
// seq_nibble_comp_if
//   Request/result bundle for the sequential nibble magnitude comparator.
//   master : drives START/A/B/SGN, observes BUSY/DONE/L/E/G/CYCLES
//   slave  : the comparator itself
//   Signals:
//     START  request (accepted in IDLE or DONE)
//     A, B   operands, 4*NIBBLES bits
//     SGN    1 = two's complement operands, 0 = unsigned
//     BUSY   high while nibbles are being examined
//     DONE   one-cycle result-valid pulse
//     L/E/G  A<B / A==B / A>B
//     CYCLES nibbles examined for the last result
// -----------------------------------------------------------------------------
interface seq_nibble_comp_if #(
   parameter int NIBBLES = 4
) ();
   localparam int W = 4 * NIBBLES;

   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         SGN;
   logic         BUSY;
   logic         DONE;
   logic         L;
   logic         E;
   logic         G;
   logic [4:0]   CYCLES;

   modport master (
      output START, A, B, SGN,
      input  BUSY, DONE, L, E, G, CYCLES
   );

   modport slave (
      input  START, A, B, SGN,
      output BUSY, DONE, L, E, G, CYCLES
   );
endinterface

// File: rtl/seq_nibble_comp.sv
// -----------------------------------------------------------------------------
// seq_nibble_comp
//   Multi-cycle magnitude comparator. Walks the captured operands one nibble
//   per clock, MSB nibble first, holding the less/equal/greater cascade in a
//   register instead of a long combinational comparator chain.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  seq_nibble_comp_if.slave (START/A/B/SGN in, BUSY/DONE/L/E/G/CYCLES out)
//   Parameters:
//     NIBBLES    nibbles per operand (1..16)
//     EARLY_EXIT 1 = stop at first unequal nibble, 0 = fixed NIBBLES latency
// -----------------------------------------------------------------------------
module seq_nibble_comp #(
   parameter int NIBBLES    = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic               clk,
   input logic               rst,
   seq_nibble_comp_if.slave  bus
);
   localparam int W = 4 * NIBBLES;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {C_EQ, C_LT, C_GT} casc_t;

   state_t       state, state_nx;
   casc_t        casc, casc_nx;
   logic [W-1:0] a_q, b_q;
   logic         sgn_q;
   logic [3:0]   idx;
   logic [3:0]   nib_a, nib_b;
   logic         flip;
   logic         last;
   logic         accept;
   logic         l_q, e_q, g_q;
   logic [4:0]   cyc_q;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      accept  = 1'b0;
      flip    = 1'b0;
      nib_a   = '0;
      nib_b   = '0;
      casc_nx = casc;
      last    = 1'b0;

      accept = bus.START && (state != S_RUN);

      // Inverting the sign bit of the top nibble maps two's complement order
      // onto unsigned order, so the same unsigned nibble compare serves both.
      flip  = sgn_q && (idx == 4'(NIBBLES - 1));
      nib_a = 4'(a_q >> {idx, 2'b00}) ^ {flip, 3'b000};
      nib_b = 4'(b_q >> {idx, 2'b00}) ^ {flip, 3'b000};

      // A decision made on a more significant nibble is never overturned.
      if (casc == C_EQ) begin
         if (nib_a < nib_b)      casc_nx = C_LT;
         else if (nib_a > nib_b) casc_nx = C_GT;
      end

      last = (idx == 4'd0) || (EARLY_EXIT && (casc_nx != C_EQ));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.START) state_nx = S_RUN;
         S_RUN:   if (last)      state_nx = S_DONE;
         S_DONE:  state_nx = bus.START ? S_RUN : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: operand, index and cascade registers carry no reset; they are
   // always loaded on an accepted START before anything reads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= bus.A;
         b_q   <= bus.B;
         sgn_q <= bus.SGN;
         idx   <= 4'(NIBBLES - 1);
         casc  <= C_EQ;
      end else if (state == S_RUN) begin
         casc <= casc_nx;
         if (!last) idx <= idx - 4'd1;
      end
   end

   // Results clear on acceptance and hold after DONE until the next START.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         l_q   <= 1'b0;
         e_q   <= 1'b0;
         g_q   <= 1'b0;
         cyc_q <= '0;
      end else if ((state == S_RUN) && last) begin
         l_q   <= (casc_nx == C_LT);
         e_q   <= (casc_nx == C_EQ);
         g_q   <= (casc_nx == C_GT);
         cyc_q <= 5'(NIBBLES) - 5'(idx);
      end
   end

   assign bus.BUSY   = (state == S_RUN);
   assign bus.DONE   = (state == S_DONE);
   assign bus.L      = l_q;
   assign bus.E      = e_q;
   assign bus.G      = g_q;
   assign bus.CYCLES = cyc_q;
endmodule

// File: tb/tb_seq_nibble_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_nibble_comp
//   Directed bench for seq_nibble_comp. Two instances (EARLY_EXIT=1 and
//   EARLY_EXIT=0, NIBBLES=4) share the same stimulus; expected values are
//   hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_seq_nibble_comp;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        sgn;

   int total = 0;
   int bad   = 0;

   seq_nibble_comp_if #(.NIBBLES(4)) ee_if ();
   seq_nibble_comp_if #(.NIBBLES(4)) fx_if ();

   assign ee_if.START = start;
   assign ee_if.A     = a;
   assign ee_if.B     = b;
   assign ee_if.SGN   = sgn;
   assign fx_if.START = start;
   assign fx_if.A     = a;
   assign fx_if.B     = b;
   assign fx_if.SGN   = sgn;

   seq_nibble_comp #(.NIBBLES(4), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .rst(rst), .bus(ee_if)
   );
   seq_nibble_comp #(.NIBBLES(4), .EARLY_EXIT(1'b0)) dut_fx (
      .clk(clk), .rst(rst), .bus(fx_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle past it before driving or sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] leg_ee();
      return {ee_if.L, ee_if.E, ee_if.G};
   endfunction

   function automatic logic [2:0] leg_fx();
      return {fx_if.L, fx_if.E, fx_if.G};
   endfunction

   // One START pulse to both instances; waits (bounded) for each DONE.
   task automatic run_op(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic s_i, input logic [2:0] exp_leg_ee, input int exp_cyc_ee,
                         input logic [2:0] exp_leg_fx, input int exp_cyc_fx);
      int n, lat_ee, lat_fx, n_busy;
      logic got_ee, got_fx;
      logic [2:0] r_leg_ee, r_leg_fx;
      logic [4:0] r_cyc_ee, r_cyc_fx;
      a = a_i; b = b_i; sgn = s_i; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_acc_leg"}, 32'(leg_ee()), 32'd0);
      check({tag, "_acc_cyc"}, 32'(ee_if.CYCLES), 32'd0);
      n_busy = ee_if.BUSY ? 1 : 0;
      n = 0; lat_ee = 0; lat_fx = 0;
      got_ee = 1'b0; got_fx = 1'b0;
      r_leg_ee = '0; r_leg_fx = '0; r_cyc_ee = '0; r_cyc_fx = '0;
      while (!(got_ee && got_fx) && n < 40) begin
         tick();
         n++;
         if (!got_ee) begin
            if (ee_if.DONE) begin
               got_ee = 1'b1; lat_ee = n; r_leg_ee = leg_ee(); r_cyc_ee = ee_if.CYCLES;
            end else if (ee_if.BUSY) begin
               n_busy++;
            end
         end
         if (!got_fx && fx_if.DONE) begin
            got_fx = 1'b1; lat_fx = n; r_leg_fx = leg_fx(); r_cyc_fx = fx_if.CYCLES;
         end
      end
      check({tag, "_ee_lat"},  32'(lat_ee),   32'(exp_cyc_ee));
      check({tag, "_ee_busy"}, 32'(n_busy),   32'(exp_cyc_ee));
      check({tag, "_ee_leg"},  32'(r_leg_ee), 32'(exp_leg_ee));
      check({tag, "_ee_cyc"},  32'(r_cyc_ee), 32'(exp_cyc_ee));
      check({tag, "_fx_lat"},  32'(lat_fx),   32'd4);
      check({tag, "_fx_leg"},  32'(r_leg_fx), 32'(exp_leg_fx));
      check({tag, "_fx_cyc"},  32'(r_cyc_fx), 32'(exp_cyc_fx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
      tick();
      tick();
      check("rst_ee_busy", 32'(ee_if.BUSY),   32'd0);
      check("rst_ee_done", 32'(ee_if.DONE),   32'd0);
      check("rst_ee_leg",  32'(leg_ee()),     32'd0);
      check("rst_ee_cyc",  32'(ee_if.CYCLES), 32'd0);
      check("rst_fx_leg",  32'(leg_fx()),     32'd0);
      rst = 1'b0;
      tick();

      // tag, A, B, SGN, ee {L,E,G}, ee cycles, fx {L,E,G}, fx cycles
      run_op("eq",   16'h1234, 16'h1234, 1'b0, 3'b010, 4, 3'b010, 4);
      run_op("sgn0", 16'h9000, 16'h1FFF, 1'b0, 3'b001, 1, 3'b001, 4);
      run_op("sgn1", 16'h9000, 16'h1FFF, 1'b1, 3'b100, 1, 3'b100, 4);
      run_op("mid",  16'h12F0, 16'h1300, 1'b0, 3'b100, 2, 3'b100, 4);

      // Results must hold while idle.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_leg", 32'(leg_ee()),     32'b100);
         check("hold_cyc", 32'(ee_if.CYCLES), 32'd2);
      end

      run_op("fx0", 16'hF000, 16'h0000, 1'b0, 3'b001, 1, 3'b001, 4);
      run_op("fx1", 16'hF000, 16'h0000, 1'b1, 3'b100, 1, 3'b100, 4);

      // Back-to-back: START stays high through RUN (ignored) and DONE (accepted).
      a = 16'h0001; b = 16'h0000; sgn = 1'b0; start = 1'b1;
      tick();
      check("b2b_busy0", 32'(ee_if.BUSY), 32'd1);
      a = 16'h0000; b = 16'hFFFF;
      tick(); tick(); tick();
      check("b2b_busy3", 32'(ee_if.BUSY), 32'd1);
      tick();
      check("b2b_done1",   32'(ee_if.DONE),   32'd1);
      check("b2b_leg1",    32'(leg_ee()),     32'b001);
      check("b2b_cyc1",    32'(ee_if.CYCLES), 32'd4);
      check("b2b_fx_leg1", 32'(leg_fx()),     32'b001);
      tick();
      check("b2b_acc_busy", 32'(ee_if.BUSY),   32'd1);
      check("b2b_acc_done", 32'(ee_if.DONE),   32'd0);
      check("b2b_acc_leg",  32'(leg_ee()),     32'd0);
      check("b2b_acc_cyc",  32'(ee_if.CYCLES), 32'd0);
      start = 1'b0;
      tick();
      check("b2b_done2", 32'(ee_if.DONE),   32'd1);
      check("b2b_leg2",  32'(leg_ee()),     32'b100);
      check("b2b_cyc2",  32'(ee_if.CYCLES), 32'd1);
      tick(); tick(); tick();
      check("b2b_fx_done2", 32'(fx_if.DONE),   32'd1);
      check("b2b_fx_leg2",  32'(leg_fx()),     32'b100);
      check("b2b_fx_cyc2",  32'(fx_if.CYCLES), 32'd4);
      tick();

      // Reset during the second RUN cycle.
      a = 16'hAAAA; b = 16'hAAAA; sgn = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("mrst_busy",    32'(ee_if.BUSY),   32'd0);
      check("mrst_done",    32'(ee_if.DONE),   32'd0);
      check("mrst_leg",     32'(leg_ee()),     32'd0);
      check("mrst_cyc",     32'(ee_if.CYCLES), 32'd0);
      check("mrst_fx_busy", 32'(fx_if.BUSY),   32'd0);
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ee_if.DONE || fx_if.DONE) dcount++;
      end
      check("mrst_no_done", 32'(dcount), 32'd0);
      run_op("post", 16'h0000, 16'h0001, 1'b0, 3'b100, 4, 3'b100, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_nibble_comp.md
Name: seq_nibble_comp

Overview:
- Multi-cycle magnitude comparator for wide operands. It walks the operands one 4-bit nibble per clock, MSB nibble first.
- It keeps the less/equal/greater cascade state in registers instead of chaining combinational 4-bit comparator stages.
- It sits beside the combinational 4-bit cascadable comparator. It uses the same L/E/G result encoding, but produces the cascade sequentially for datapaths where a long combinational chain cannot meet timing.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal values 1..16.
- EARLY_EXIT, 1, 1 = finish at the first unequal nibble; 0 = always examine all NIBBLES nibbles (fixed latency).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when the FSM is in IDLE or DONE.
- A  in  W  operand A; captured on the accepted START edge.
- B  in  W  operand B; captured on the accepted START edge.
- SGN  in  1  1 = A/B are two's complement, 0 = unsigned; captured with A/B.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; result is valid.
- L  out  1  A < B.
- E  out  1  A == B.
- G  out  1  A > B.
- CYCLES  out  5  number of nibbles examined for the last result (1..NIBBLES).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - BUSY=0, DONE=0, L=E=G=0, CYCLES=0.
  - The captured operand registers and the nibble index are don't-care.
  - Reset overrides START in the same cycle.
- FSM states and transitions:
  - IDLE: START=1 -> RUN.
  - RUN: evaluates one nibble per cycle.
  - DONE: lasts exactly one cycle, then IDLE. START=1 in DONE -> RUN directly (back-to-back operation).
- START acceptance edge (IDLE or DONE with START=1):
  - capture A, B and SGN.
  - nibble index idx = NIBBLES-1.
  - internal cascade state = "equal".
  - L=E=G=0, CYCLES=0.
  - BUSY=1 from the next cycle.
- Each RUN edge compares nibble idx of the captured A against nibble idx of the captured B, unsigned.
  - Exception: when SGN=1 and idx=NIBBLES-1, bit 3 of both nibbles is inverted before the compare. This is the sign-bit flip.
  - Cascade rule: a prior L or G decision is held. Only when the state is still "equal" does the nibble compare set L or G.
- EARLY_EXIT=1:
  - nibbles unequal -> register L/G, E=0, go to DONE.
  - nibbles equal and idx=0 -> E=1, go to DONE.
  - otherwise idx decrements.
- EARLY_EXIT=0: the FSM always runs NIBBLES RUN cycles. The result is decided by the first unequal nibble.
- Latency:
  - k = number of nibbles examined. If START is accepted at edge 0, the result is registered at edge k.
  - DONE=1 and BUSY=0 during the cycle after edge k.
  - DONE drops after edge k+1 unless it is re-triggered via START.
- Results:
  - L/E/G/CYCLES hold their value after DONE until the next accepted START or reset.
  - After any completion, exactly one of L/E/G is high.
- START during RUN is ignored. The captured operands are unaffected, as are A/B/SGN changes during RUN.
- rst mid-RUN: abort to IDLE with all outputs zero. No DONE pulse is produced.
- NIBBLES=1: a single RUN cycle; SGN applies to that nibble.
- CYCLES is a 5-bit register. It is zero-extended and never wraps for legal NIBBLES.

Test Plan (NIBBLES=4 unless noted):
- Equal operands, A=B=0x1234, SGN=0, START pulse -> BUSY for 4 cycles; DONE 4 clocks after the START edge; L/E/G=0/1/0; CYCLES=4.
- Sign handling, A=0x9000, B=0x1FFF:
  - SGN=0 -> G=1, CYCLES=1, DONE 1 clock after START.
  - repeat with SGN=1 -> L=1, CYCLES=1.
- Mid-operand difference, A=0x12F0, B=0x1300, SGN=0 -> L=1, CYCLES=2; results held for 5 idle cycles after DONE.
- Back-to-back and ignored START:
  - START A=0x0001, B=0x0000; re-assert START with A=0x0000, B=0xFFFF while BUSY -> first result G=1, CYCLES=4.
  - START held high in the DONE cycle -> second operation (current A/B) starts immediately; L/E/G clear to 000 at acceptance.
- Reset mid-operation: rst=1 during the 2nd RUN cycle of A=B=0xAAAA -> next cycle BUSY=DONE=L=E=G=0, CYCLES=0; no DONE pulse follows; a fresh START of A=0x0000, B=0x0001 completes with L=1, CYCLES=4.
- EARLY_EXIT=0: A=0xF000, B=0x0000, SGN=0 -> G=1, CYCLES=4, DONE 4 clocks after START; with SGN=1 -> L=1, CYCLES=4.
